// File: rtl/p1v_reset_seq.sv
// p1v_reset_seq: reset sequencer for the p1v core.
// Waits for MMCM lock, debounces the reset button and holds reset after release.
module p1v_reset_seq #(
    parameter int HOLD_CYCLES = 8000000,
    parameter int DEB_CYCLES  = 160000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock_160,
    input  logic       reset,
    input  logic       locked,
    input  logic       rts,
    input  logic       btn_n,
    output logic       resn,
    output logic [1:0] state,
    output logic [2:0] cause
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);

    typedef enum logic [1:0] {
        LOCKWAIT = 2'b00,
        ASSERT   = 2'b01,
        HOLD     = 2'b10,
        RUN      = 2'b11
    } state_t;

    // bit order in each stage: {btn_n, rts, locked}
    logic [2:0]    r_sync [SYNC_STAGES];
    logic          r_btn_db;
    logic [DW-1:0] r_deb_cnt;
    state_t        r_state;
    logic [HW-1:0] r_hold_cnt;
    logic          r_resn;
    logic [2:0]    r_cause;

    logic   w_locked_s;
    logic   w_rts_s;
    logic   w_btn_s;
    logic   w_req;
    logic   w_leave;
    state_t w_next;

    assign w_locked_s = r_sync[SYNC_STAGES-1][0];
    assign w_rts_s    = r_sync[SYNC_STAGES-1][1];
    assign w_btn_s    = r_sync[SYNC_STAGES-1][2];

    // Synchronize the three asynchronous inputs; reset clears them to "request".
    always_ff @(posedge clock_160) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= {btn_n, rts, locked};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Debounce: flip the button level only after DEB_CYCLES straight disagreements.
    always_ff @(posedge clock_160) begin
        if (reset) begin
            r_btn_db  <= 1'b0;
            r_deb_cnt <= '0;
        end else if (w_btn_s != r_btn_db) begin
            if (r_deb_cnt == DEB_LAST) begin
                r_btn_db  <= ~r_btn_db;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_ONE;
            end
        end else begin
            r_deb_cnt <= '0;
        end
    end

    assign w_req = ~w_rts_s | ~r_btn_db;

    // Next-state decode; lock loss outranks a reset request everywhere.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            LOCKWAIT: begin
                if (w_locked_s) w_next = ASSERT;
            end
            ASSERT: begin
                if (!w_locked_s) w_next = LOCKWAIT;
                else if (!w_req) w_next = HOLD;
            end
            HOLD: begin
                if (!w_locked_s)            w_next = LOCKWAIT;
                else if (w_req)             w_next = ASSERT;
                else if (r_hold_cnt == '0)  w_next = RUN;
            end
            RUN: begin
                if (!w_locked_s) w_next = LOCKWAIT;
                else if (w_req)  w_next = ASSERT;
            end
        endcase
    end

    assign w_leave = ((r_state == HOLD) || (r_state == RUN)) &&
                     ((w_next == ASSERT) || (w_next == LOCKWAIT));

    // State, hold counter, registered resn and sticky cause capture.
    always_ff @(posedge clock_160) begin
        if (reset) begin
            r_state    <= LOCKWAIT;
            r_hold_cnt <= '0;
            r_resn     <= 1'b0;
            r_cause    <= 3'b001;
        end else begin
            r_state <= w_next;
            r_resn  <= (w_next == RUN);
            if (r_state == ASSERT) begin
                r_hold_cnt <= HOLD_LOAD;
            end else if ((r_state == HOLD) && (w_next == HOLD)) begin
                r_hold_cnt <= r_hold_cnt - HOLD_ONE;
            end
            if (w_leave) begin
                r_cause <= {~r_btn_db, ~w_rts_s, ~w_locked_s};
            end
        end
    end

    assign resn  = r_resn;
    assign state = r_state;
    assign cause = r_cause;

endmodule

// File: tb/tb_p1v_reset_seq.sv
// tb_p1v_reset_seq: scenario and randomized bench for p1v_reset_seq.
// Reference model tracks delays, run lengths and hold time with plain integers.
module tb_p1v_reset_seq;

    localparam int HOLD = 10;
    localparam int DEB  = 4;
    localparam int SYNC = 2;

    localparam logic [1:0] LW = 2'd0;
    localparam logic [1:0] AS = 2'd1;
    localparam logic [1:0] HO = 2'd2;
    localparam logic [1:0] RU = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked;
    logic       rts;
    logic       btn_n;
    logic       resn;
    logic [1:0] state;
    logic [2:0] cause;

    int errors = 0;
    int checks = 0;

    // reference model
    bit         m_lq [SYNC];
    bit         m_rq [SYNC];
    bit         m_bq [SYNC];
    bit         m_db;
    int         m_run;
    logic [1:0] m_state;
    int         m_held;
    bit         m_resn;
    logic [2:0] m_cause;

    always #5 clk = ~clk;

    p1v_reset_seq #(
        .HOLD_CYCLES(HOLD),
        .DEB_CYCLES (DEB),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock_160(clk),
        .reset    (reset),
        .locked   (locked),
        .rts      (rts),
        .btn_n    (btn_n),
        .resn     (resn),
        .state    (state),
        .cause    (cause)
    );

    task automatic model_edge();
        bit ls, rs, bs, req;
        logic [1:0] nxt;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) begin
                m_lq[i] = 0; m_rq[i] = 0; m_bq[i] = 0;
            end
            m_db = 0; m_run = 0; m_state = LW; m_held = 0;
            m_resn = 0; m_cause = 3'b001;
            return;
        end
        ls  = m_lq[SYNC-1];
        rs  = m_rq[SYNC-1];
        bs  = m_bq[SYNC-1];
        req = !rs || !m_db;
        nxt = m_state;
        if (!ls) nxt = LW;
        else if (m_state == LW) nxt = AS;
        else if (m_state == AS) begin
            if (!req) nxt = HO;
        end else if (req) nxt = AS;
        else if (m_state == HO) begin
            if (m_held == HOLD - 1) nxt = RU;
            else m_held++;
        end
        if (m_state == AS && nxt == HO) m_held = 0;
        if ((m_state == HO || m_state == RU) && (nxt == AS || nxt == LW))
            m_cause = {!m_db, !rs, !ls};
        m_resn  = (nxt == RU);
        m_state = nxt;
        if (bs != m_db) begin
            m_run++;
            if (m_run == DEB) begin
                m_db  = !m_db;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) begin
            m_lq[i] = m_lq[i-1]; m_rq[i] = m_rq[i-1]; m_bq[i] = m_bq[i-1];
        end
        m_lq[0] = locked; m_rq[0] = rts; m_bq[0] = btn_n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; locked = 1; rts = 1; btn_n = 1;
        repeat (3) tick();
        checks++;
        if (state !== LW) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", state, LW);
        end
        checks++;
        if (resn !== 1'b0) begin
            errors++;
            $display("FAIL reset_resn got=%b exp=0", resn);
        end
        checks++;
        if (cause !== 3'b001) begin
            errors++;
            $display("FAIL reset_cause got=%b exp=001", cause);
        end
    endtask

    task automatic test_powerup();
        reset = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if (state !== m_state || resn !== m_resn || cause !== m_cause) begin
                errors++;
                $display("FAIL pwr_model e=%0d st=%0d/%0d resn=%b/%b cause=%b/%b",
                         e, state, m_state, resn, m_resn, cause, m_cause);
            end
            if (e == 3 || e == 7 || e == 16 || e == 17) begin
                checks++;
                if ((e == 3 && state !== AS) || (e == 7 && state !== HO) ||
                    (e == 16 && resn !== 1'b0) ||
                    (e == 17 && (resn !== 1'b1 || cause !== 3'b001))) begin
                    errors++;
                    $display("FAIL pwr_timing e=%0d st=%0d resn=%b cause=%b",
                             e, state, resn, cause);
                end
            end
        end
    endtask

    task automatic test_rts_pulse();
        int low_cnt = 0;
        int first_as = -1;
        logic [2:0] as_cause = 3'b000;
        rts = 0;
        tick();
        rts = 1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            checks++;
            if (state !== m_state || resn !== m_resn || cause !== m_cause) begin
                errors++;
                $display("FAIL rts_model k=%0d st=%0d/%0d resn=%b/%b cause=%b/%b",
                         k, state, m_state, resn, m_resn, cause, m_cause);
            end
            if (resn === 1'b0) low_cnt++;
            if (state === AS && first_as < 0) begin
                first_as = k;
                as_cause = cause;
            end
        end
        checks++;
        if (first_as != 2) begin
            errors++;
            $display("FAIL rts_latency got=%0d exp=2", first_as);
        end
        checks++;
        if (as_cause !== 3'b010) begin
            errors++;
            $display("FAIL rts_cause got=%b exp=010", as_cause);
        end
        checks++;
        if (low_cnt != 11) begin
            errors++;
            $display("FAIL rts_resn_low got=%0d exp=11", low_cnt);
        end
    endtask

    task automatic test_button();
        int hold_cnt = 0;
        logic [2:0] as_cause = 3'b000;
        bit seen_as = 0;
        for (int k = 0; k < 12; k++) begin
            btn_n = (k < 3) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (state !== RU || state !== m_state || resn !== m_resn) begin
                errors++;
                $display("FAIL btn_short k=%0d st=%0d/%0d resn=%b/%b",
                         k, state, m_state, resn, m_resn);
            end
        end
        for (int k = 0; k < 40; k++) begin
            btn_n = (k < 6) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (state !== m_state || resn !== m_resn || cause !== m_cause) begin
                errors++;
                $display("FAIL btn_model k=%0d st=%0d/%0d resn=%b/%b cause=%b/%b",
                         k, state, m_state, resn, m_resn, cause, m_cause);
            end
            if (state === AS && !seen_as) begin
                seen_as  = 1;
                as_cause = cause;
            end
            if (state === HO) hold_cnt++;
        end
        checks++;
        if (as_cause !== 3'b100) begin
            errors++;
            $display("FAIL btn_cause got=%b exp=100", as_cause);
        end
        checks++;
        if (hold_cnt != HOLD || state !== RU) begin
            errors++;
            $display("FAIL btn_hold got=%0d st=%0d exp=%0d st=3",
                     hold_cnt, state, HOLD);
        end
    endtask

    task automatic test_lock_in_hold();
        int hold_cnt = 0;
        bit reached = 0;
        rts = 0;
        tick();
        rts = 1;
        for (int k = 0; k < 10 && !reached; k++) begin
            tick();
            if (state === HO) reached = 1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL lock_reach_hold st=%0d exp=2", state);
        end
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            locked = 0;
            tick();
            checks++;
            if (resn !== 1'b0 || state !== m_state || cause !== m_cause) begin
                errors++;
                $display("FAIL lock_drop k=%0d st=%0d/%0d resn=%b cause=%b/%b",
                         k, state, m_state, resn, cause, m_cause);
            end
        end
        checks++;
        if (state !== LW || cause !== 3'b001) begin
            errors++;
            $display("FAIL lock_lw st=%0d cause=%b exp st=0 cause=001",
                     state, cause);
        end
        locked = 1;
        for (int k = 0; k < 25; k++) begin
            tick();
            checks++;
            if (state !== m_state || resn !== m_resn || cause !== m_cause) begin
                errors++;
                $display("FAIL lock_relock k=%0d st=%0d/%0d resn=%b/%b",
                         k, state, m_state, resn, m_resn);
            end
            if (state === HO) hold_cnt++;
        end
        checks++;
        if (hold_cnt != HOLD || state !== RU) begin
            errors++;
            $display("FAIL lock_rehold got=%0d st=%0d exp=%0d st=3",
                     hold_cnt, state, HOLD);
        end
    endtask

    task automatic test_simultaneous();
        bit saw_as = 0;
        for (int k = 0; k < 4; k++) begin
            rts    = (k < 3) ? 1'b0 : 1'b1;
            locked = (k < 3) ? 1'b0 : 1'b1;
            tick();
            if (state === AS) saw_as = 1;
        end
        checks++;
        if (saw_as || state !== LW || cause !== 3'b011) begin
            errors++;
            $display("FAIL simul st=%0d cause=%b as=%b exp st=0 cause=011 as=0",
                     state, cause, saw_as);
        end
        for (int k = 0; k < 25; k++) begin
            tick();
            checks++;
            if (state !== m_state || resn !== m_resn || cause !== m_cause) begin
                errors++;
                $display("FAIL simul_model k=%0d st=%0d/%0d resn=%b/%b",
                         k, state, m_state, resn, m_resn);
            end
        end
        checks++;
        if (state !== RU) begin
            errors++;
            $display("FAIL simul_recover st=%0d exp=3", state);
        end
    endtask

    task automatic test_reset_mid_hold();
        rts = 0;
        tick();
        rts = 1;
        repeat (6) tick();
        checks++;
        if (state !== HO || cause !== 3'b010) begin
            errors++;
            $display("FAIL rsth_pre st=%0d cause=%b exp st=2 cause=010",
                     state, cause);
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (state !== LW || cause !== 3'b001 || resn !== 1'b0) begin
            errors++;
            $display("FAIL rsth_post st=%0d cause=%b resn=%b exp 0/001/0",
                     state, cause, resn);
        end
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (state !== m_state || resn !== m_resn || cause !== m_cause) begin
                errors++;
                $display("FAIL rsth_model k=%0d st=%0d/%0d resn=%b/%b",
                         k, state, m_state, resn, m_resn);
            end
        end
        checks++;
        if (state !== RU) begin
            errors++;
            $display("FAIL rsth_recover st=%0d exp=3", state);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            reset  = ($urandom_range(0, 399) == 0);
            locked = ($urandom_range(0, 119) != 0);
            rts    = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 9) == 0) btn_n = ~btn_n;
            tick();
            checks++;
            if (state !== m_state || resn !== m_resn || cause !== m_cause) begin
                errors++;
                $display("FAIL rand k=%0d st=%0d/%0d resn=%b/%b cause=%b/%b",
                         k, state, m_state, resn, m_resn, cause, m_cause);
            end
        end
        reset = 0; locked = 1; rts = 1; btn_n = 1;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_rts_pulse();
        test_button();
        test_lock_in_hold();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
